memory_arbiter: RTL and testbench

Shares the single RAM port between the instruction fetch path and the data request path of the pipelined CPU. It captures one request at a time and drives the RAM until it signals completion. It then returns the result to the winning requester with a one-cycle hit pulse. The block sits between the request unit / caches and the RAM model, and all its outputs are registered.

---
 rtl/memory_arbiter.sv | 173 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data requests; data has priority.
// Optional MEMORY_ARBITER_FAIRNESS_EN bounds consecutive data grants while a fetch waits.
module memory_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              ramready,
  input  logic [DATA_W-1:0] ramload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              wr_q, wr_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic              dreq;
  logic              grant_i;
  logic              grant_d;

  assign dreq = dREN | dWEN;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
  localparam int               CNT_W   = $clog2(MAX_DBURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBURST);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances on data grants that bypassed a waiting fetch.
  always_comb begin
    cnt_d   = cnt_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (iREN && (cnt_q == CNT_MAX)) begin
        grant_i = 1'b1;
        cnt_d   = '0;
      end else if (dreq) begin
        grant_d = 1'b1;
        if (!iREN)
          cnt_d = '0;
        else if (cnt_q != CNT_MAX)
          cnt_d = cnt_q + 1'b1;
      end else if (iREN) begin
        grant_i = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  always_comb begin
    grant_d = (state_q == IDLE) && dreq;
    grant_i = (state_q == IDLE) && !dreq && iREN;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    iload_d = iload_q;
    dload_d = dload_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          ren_d   = !dWEN;
          wen_d   = dWEN;
        end else if (grant_i) begin
          state_d = IACC;
          addr_d  = iaddr;
          store_d = '0;
          wr_d    = 1'b0;
          ren_d   = 1'b1;
          wen_d   = 1'b0;
        end
      end
      IACC, DACC: begin
        if (ramready) begin
          state_d = RESP;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          if (state_q == DACC) begin
            dhit_d = 1'b1;
            if (!wr_q)
              dload_d = ramload;
          end else begin
            ihit_d  = 1'b1;
            iload_d = ramload;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
    end
  end

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = ihit_q;
  assign iload    = iload_q;
  assign dhit     = dhit_q;
  assign dload    = dload_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: RAM responder with programmable latency and a hit scoreboard.
module tb_memory_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ramready;
  logic [31:0] ram_data;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;

  int   vectors = 0;
  int   miscompares = 0;
  int   hits = 0;
  int   ihits = 0;
  int   cyc = 0;
  int   ram_lat = 1;
  int   scnt = 0;
  exp_t sb[$];

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DBURST(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramready(ramready), .ramload(ram_data),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model: ramready after ram_lat strobe cycles (0 = never); each response bumps the data word.
  always @(negedge CLK) begin
    if ((ramREN || ramWEN) && !ramready) begin
      scnt++;
      if (scnt == ram_lat) ramready = 1'b1;
    end else begin
      if (ramready) ram_data = ram_data + 32'd1;
      ramready = 1'b0;
      scnt = 0;
    end
  end

  always @(negedge CLK) begin
    if (ramREN || ramWEN) chk("strobe_excl", 64'(ramREN && ramWEN), 64'd0);
    if (ihit || dhit) begin
      exp_t e;
      hits++;
      if (ihit) ihits++;
      if (sb.size() == 0) begin
        chk("unexpected_hit", {62'd0, ihit, dhit}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hit_src", {62'd0, ihit, dhit}, e.is_d ? 64'd1 : 64'd2);
        chk("hit_data", e.is_d ? 64'(dload) : 64'(iload), 64'(e.data));
      end
    end
  end

  task automatic wait_hit(input bit want_d, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (want_d ? dhit : ihit) begin
        at = cyc;
        break;
      end
    end
    chk(want_d ? "dhit_timeout" : "ihit_timeout", 64'(at < 0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   td, ti, h0, ih0;
    bit   fair;
    logic [31:0] exp_next;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramready = 1'b0; ram_data = 32'h2408_0005; exp_next = 32'h2408_0005;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_strobes_hits", {60'd0, ramREN, ramWEN, ihit, dhit}, 64'd0);
    chk("rst_addr_store", {ramaddr, ramstore}, 64'd0);
    chk("rst_loads", {iload, dload}, 64'd0);

    // Instruction read, ramready on third strobe cycle
    @(posedge CLK); #1;
    RST = 1'b0; iREN = 1'b1; iaddr = 32'h0000_0040; ram_lat = 3;
    sb.push_back('{is_d: 1'b0, data: exp_next}); exp_next++;
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK); @(negedge CLK);
      chk("ird_strobe", {62'd0, ramREN, ramWEN}, 64'd2);
      chk("ird_addr", 64'(ramaddr), 64'h40);
      chk("ird_nohit", 64'(ihit), 64'd0);
    end
    @(posedge CLK); @(negedge CLK);
    chk("ird_ihit", 64'(ihit), 64'd1);
    chk("ird_iload", 64'(iload), 64'h2408_0005);
    chk("ird_strobe_off", {62'd0, ramREN, ramWEN}, 64'd0);
    @(posedge CLK); #1 iREN = 1'b0;
    @(negedge CLK);
    chk("ird_idle", {61'd0, ramREN, ramWEN, ihit}, 64'd0);
    @(posedge CLK); @(negedge CLK);
    chk("ird_stay_idle", {62'd0, ramREN, ramWEN}, 64'd0);

    // Data write (dREN also high: write wins), single-cycle RAM
    @(posedge CLK); #1;
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF; ram_lat = 1;
    sb.push_back('{is_d: 1'b1, data: 32'd0}); exp_next++;
    @(posedge CLK); @(negedge CLK);
    chk("wr_strobe", {62'd0, ramREN, ramWEN}, 64'd1);
    chk("wr_store", 64'(ramstore), 64'hDEAD_BEEF);
    chk("wr_addr", 64'(ramaddr), 64'h100);
    @(posedge CLK); @(negedge CLK);
    chk("wr_dhit", 64'(dhit), 64'd1);
    chk("wr_strobe_off", {62'd0, ramREN, ramWEN}, 64'd0);
    chk("wr_dload_held", 64'(dload), 64'd0);
    @(posedge CLK); #1 dWEN = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    chk("wr_single_pulse", 64'(dhit), 64'd0);

    // Simultaneous requests: data first, fetch three cycles after dhit
    @(posedge CLK); #1;
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h104;
    sb.push_back('{is_d: 1'b1, data: exp_next}); exp_next++;
    sb.push_back('{is_d: 1'b0, data: exp_next}); exp_next++;
    wait_hit(1'b1, 20, td);
    @(posedge CLK); #1 dREN = 1'b0;
    wait_hit(1'b0, 20, ti);
    chk("prio_gap", 64'(ti - td), 64'd3);
    @(posedge CLK); #1 iREN = 1'b0;

    // Reset during a stalled data access
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h200; ram_lat = 0;
    @(posedge CLK); @(negedge CLK);
    chk("rstmid_strobe", 64'(ramREN), 64'd1);
    @(posedge CLK); #1 RST = 1'b1; dREN = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("rstmid_ctrl", {60'd0, ramREN, ramWEN, ihit, dhit}, 64'd0);
    chk("rstmid_addr_store", {ramaddr, ramstore}, 64'd0);
    chk("rstmid_loads", {iload, dload}, 64'd0);
    @(posedge CLK); #1 RST = 1'b0;
    h0 = hits;
    repeat (6) @(negedge CLK);
    chk("rstmid_no_hit", 64'(hits - h0), 64'd0);

    // Continuous iREN + dREN: grant order depends on fairness build
    @(posedge CLK); #1;
    ram_lat = 1; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h300; daddr = 32'h400;
    h0 = hits; ih0 = ihits;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{is_d: fair ? (i % 5 != 4) : 1'b1, data: exp_next});
      exp_next++;
    end
    for (int i = 0; i < 300 && hits < h0 + 10; i++) begin
      @(negedge CLK); #1;
    end
    chk("starve_hits", 64'(hits - h0), 64'd10);
    @(posedge CLK); #1 iREN = 1'b0; dREN = 1'b0;
    chk("starve_ihits", 64'(ihits - ih0), fair ? 64'd2 : 64'd0);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_idle", {62'd0, ramREN, ramWEN}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
